alu_seq_muldiv: RTL and testbench

//  Handshaked, parametrised successor of the single-cycle MIPS ALU. Same 6-bit ALUFun op set plus

---
 rtl/alu_seq_muldiv_pkg.sv | 37 +++
 rtl/alu_seq_muldiv_if.sv | 33 +++
 rtl/alu_seq_muldiv_iter.sv | 128 ++++++++++++
 rtl/alu_seq_muldiv.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_muldiv_pkg                                           |
// | Description : ALUFun opcodes and control FSM state encoding.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_seq_muldiv_pkg;

  localparam logic [5:0] C_FUN_ADD  = 6'b000000;
  localparam logic [5:0] C_FUN_SUB  = 6'b000001;
  localparam logic [5:0] C_FUN_AND  = 6'b011000;
  localparam logic [5:0] C_FUN_OR   = 6'b011110;
  localparam logic [5:0] C_FUN_XOR  = 6'b010110;
  localparam logic [5:0] C_FUN_NOR  = 6'b010001;
  localparam logic [5:0] C_FUN_PASS = 6'b011010;
  localparam logic [5:0] C_FUN_SLL  = 6'b100000;
  localparam logic [5:0] C_FUN_SRL  = 6'b100001;
  localparam logic [5:0] C_FUN_SRA  = 6'b100011;
  localparam logic [5:0] C_FUN_EQ   = 6'b110011;
  localparam logic [5:0] C_FUN_NE   = 6'b110001;
  localparam logic [5:0] C_FUN_LT   = 6'b110101;
  localparam logic [5:0] C_FUN_LEZ  = 6'b111101;
  localparam logic [5:0] C_FUN_LTZ  = 6'b111011;
  localparam logic [5:0] C_FUN_GTZ  = 6'b111111;
  localparam logic [5:0] C_FUN_MULT = 6'b001000;
  localparam logic [5:0] C_FUN_DIV  = 6'b001001;
  localparam logic [5:0] C_FUN_MFHI = 6'b001010;
  localparam logic [5:0] C_FUN_MFLO = 6'b001011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_muldiv_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_muldiv_if                                            |
// | Description : Issue/result handshake bundle between decode and writeback.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_fun;
  logic             in_sign;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_z;
  logic             out_zero;
  logic             out_ovf;
  logic             out_neg;

  modport master (
    output in_valid, in_fun, in_sign, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_z, out_zero, out_ovf, out_neg
  );

  modport slave (
    input  in_valid, in_fun, in_sign, in_a, in_b, out_ready,
    output in_ready, out_valid, out_z, out_zero, out_ovf, out_neg
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_muldiv_iter                                          |
// | Description : Radix-2 shift-add multiplier / restoring divider, WIDTH      |
// |               iterations on magnitudes with sign post-correction.          |
// |               Divider present only when ALU_DIV_EN is defined.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_seq_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start_i,
`ifdef ALU_DIV_EN
  input  wire logic             is_div_i,
`endif
  input  wire logic             sign_i,
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [WIDTH-1:0]      hi_o,
  output logic [WIDTH-1:0]      lo_o
);
  localparam int                 C_CNT_W    = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

  logic               run_q;
  logic [C_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mq_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_q;
`ifdef ALU_DIV_EN
  logic               div_q;
  logic               rneg_q;
  logic               bzero_q;
  logic [WIDTH-1:0]   araw_q;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
`endif

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_acc_n;
  logic [WIDTH-1:0]   w_mq_n;
  logic [2*WIDTH-1:0] w_prod;

  assign w_a_neg = sign_i & a_i[WIDTH-1];
  assign w_b_neg = sign_i & b_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a_i : a_i;
  assign w_b_mag = w_b_neg ? -b_i : b_i;
  assign done_o  = run_q && (cnt_q == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
`ifdef ALU_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      araw_q  <= '0;
`endif
    end else if (start_i) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      acc_q  <= '0;
      mq_q   <= w_b_mag;
      opnd_q <= w_a_mag;
      neg_q  <= w_a_neg ^ w_b_neg;
`ifdef ALU_DIV_EN
      div_q   <= is_div_i;
      rneg_q  <= w_a_neg;
      bzero_q <= (b_i == '0);
      araw_q  <= a_i;
      if (is_div_i) begin
        mq_q   <= w_a_mag;
        opnd_q <= w_b_mag;
      end
`endif
    end else if (run_q) begin
      acc_q <= w_acc_n;
      mq_q  <= w_mq_n;
      if (cnt_q == C_CNT_LAST) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // One iteration per cycle; the outputs present the corrected result of the current step.
  always_comb begin
    w_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opnd_q : '0)};
    w_acc_n = w_sum[WIDTH:1];
    w_mq_n  = {w_sum[0], mq_q[WIDTH-1:1]};
    w_prod  = neg_q ? -{w_acc_n, w_mq_n} : {w_acc_n, w_mq_n};
    hi_o    = w_prod[2*WIDTH-1:WIDTH];
    lo_o    = w_prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
    w_shift = {acc_q, mq_q[WIDTH-1]};
    w_trial = w_shift - {1'b0, opnd_q};
    w_ge    = ~w_trial[WIDTH];
    if (div_q) begin
      w_acc_n = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_mq_n  = {mq_q[WIDTH-2:0], w_ge};
      lo_o    = neg_q ? -w_mq_n : w_mq_n;
      hi_o    = rneg_q ? -w_acc_n : w_acc_n;
      if (bzero_q) begin
        lo_o = '1;
        hi_o = araw_q;
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_muldiv                                               |
// | Description : Handshaked ALU with iterative MULT/DIV and HI/LO registers.  |
// |               Define ALU_DIV_EN to include the divider.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_seq_muldiv
  import alu_seq_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic         clk,
  input wire logic         reset,
  alu_seq_muldiv_if.slave  bus
);
  localparam int C_SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic              w_accept;
  logic              w_multi;
  logic              w_done;
  logic [WIDTH-1:0]  w_hi;
  logic [WIDTH-1:0]  w_lo;
  logic [WIDTH-1:0]  w_z;
  logic              w_ovf;
  logic              w_def;
  logic              w_zero;
  logic              w_neg;
  logic [WIDTH:0]    w_add;
  logic [WIDTH:0]    w_sub;
  logic              w_lt;
  logic [C_SH_W-1:0] w_sh;
  logic              w_amsb;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_z     = z_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_neg   = neg_q;

  assign w_accept = bus.in_valid && (state_q == S_IDLE);
`ifdef ALU_DIV_EN
  assign w_multi = (bus.in_fun == C_FUN_MULT) || (bus.in_fun == C_FUN_DIV);
`else
  assign w_multi = (bus.in_fun == C_FUN_MULT);
`endif

  alu_seq_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (w_accept && w_multi),
`ifdef ALU_DIV_EN
    .is_div_i(bus.in_fun == C_FUN_DIV),
`endif
    .sign_i  (bus.in_sign),
    .a_i     (bus.in_a),
    .b_i     (bus.in_b),
    .done_o  (w_done),
    .hi_o    (w_hi),
    .lo_o    (w_lo)
  );

  always_comb begin
    w_sh   = bus.in_a[C_SH_W-1:0];
    w_amsb = bus.in_a[WIDTH-1];
    w_add  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    w_sub  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    w_lt   = bus.in_sign ? ($signed(bus.in_a) < $signed(bus.in_b)) : (bus.in_a < bus.in_b);
    w_z    = '0;
    w_ovf  = 1'b0;
    w_def  = 1'b1;
    case (bus.in_fun)
      C_FUN_ADD: begin
        w_z   = w_add[WIDTH-1:0];
        w_ovf = bus.in_sign ? ((w_amsb == bus.in_b[WIDTH-1]) && (w_add[WIDTH-1] != w_amsb))
                            : w_add[WIDTH];
      end
      C_FUN_SUB: begin
        w_z   = w_sub[WIDTH-1:0];
        w_ovf = bus.in_sign ? ((w_amsb != bus.in_b[WIDTH-1]) && (w_sub[WIDTH-1] != w_amsb))
                            : w_sub[WIDTH];
      end
      C_FUN_AND:  w_z = bus.in_a & bus.in_b;
      C_FUN_OR:   w_z = bus.in_a | bus.in_b;
      C_FUN_XOR:  w_z = bus.in_a ^ bus.in_b;
      C_FUN_NOR:  w_z = ~(bus.in_a | bus.in_b);
      C_FUN_PASS: w_z = bus.in_a;
      C_FUN_SLL:  w_z = bus.in_b << w_sh;
      C_FUN_SRL:  w_z = bus.in_b >> w_sh;
      C_FUN_SRA:  w_z = $unsigned($signed(bus.in_b) >>> w_sh);
      C_FUN_EQ:   w_z = WIDTH'(bus.in_a == bus.in_b);
      C_FUN_NE:   w_z = WIDTH'(bus.in_a != bus.in_b);
      C_FUN_LT:   w_z = WIDTH'(w_lt);
      C_FUN_LEZ:  w_z = WIDTH'((bus.in_sign && w_amsb) || (bus.in_a == '0));
      C_FUN_LTZ:  w_z = WIDTH'(bus.in_sign && w_amsb);
      C_FUN_GTZ:  w_z = WIDTH'(!(bus.in_sign && w_amsb) && (bus.in_a != '0));
      C_FUN_MFHI: w_z = hi_q;
      C_FUN_MFLO: w_z = lo_q;
      C_FUN_MULT, C_FUN_DIV: w_z = '0;
      default:    w_def = 1'b0;
    endcase
    // Undefined opcodes report all flags clear, including zero.
    w_zero = w_def && (w_z == '0);
    w_neg  = w_def && bus.in_sign && w_z[WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          sign_d = bus.in_sign;
          if (w_multi) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            z_d     = w_z;
            zero_d  = w_zero;
            ovf_d   = w_ovf;
            neg_d   = w_neg;
          end
        end
      end
      S_BUSY: begin
        if (w_done) begin
          state_d = S_DONE;
          hi_d    = w_hi;
          lo_d    = w_lo;
          z_d     = w_lo;
          zero_d  = (w_lo == '0);
          ovf_d   = 1'b0;
          neg_d   = sign_q && w_lo[WIDTH-1];
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_seq_muldiv                                            |
// | Description : Directed self-checking bench for alu_seq_muldiv, WIDTH=32.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_seq_muldiv;
  import alu_seq_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  logic [31:0] held_z;

  alu_seq_muldiv_if #(.WIDTH(32)) bus ();

  alu_seq_muldiv #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one op, waits for acceptance, then counts cycles until out_valid.
  task automatic run_op(input logic [5:0] fun, input logic sign,
                        input logic [31:0] a, input logic [31:0] b, output int l);
    int n;
    bus.in_fun   = fun;
    bus.in_sign  = sign;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
    l = 1;
    while (!bus.out_valid && l < 100) begin
      tick();
      l++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [5:0] fun, input logic sign,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_z, input int exp_lat);
    int l;
    run_op(fun, sign, a, b, l);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_z"}, bus.out_z, exp_z);
    consume();
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_fun    = '0;
    bus.in_sign   = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_z",     bus.out_z,     0);
    check("rst_zero",      bus.out_zero,  0);
    check("rst_ovf",       bus.out_ovf,   0);
    check("rst_neg",       bus.out_neg,   0);
    reset = 1'b0;
    tick();

    // Signed overflow on ADD, then a 5-cycle consumer stall
    run_op(C_FUN_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, lat);
    check("add_lat",  lat, 1);
    check("add_z",    bus.out_z,    32'h8000_0000);
    check("add_ovf",  bus.out_ovf,  1);
    check("add_neg",  bus.out_neg,  1);
    check("add_zero", bus.out_zero, 0);
    held_z = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", bus.out_valid, 1);
      check("stall_z",     bus.out_z,     held_z);
      check("stall_ready", bus.in_ready,  0);
    end
    consume();
    check("bubble_ready", bus.in_ready, 1);

    run_op(C_FUN_ADD, 1'b0, 32'hFFFF_FFFF, 32'h1, lat);
    check("addu_z",    bus.out_z,    0);
    check("addu_ovf",  bus.out_ovf,  1);
    check("addu_zero", bus.out_zero, 1);
    consume();
    run_op(C_FUN_SUB, 1'b1, 32'h8000_0000, 32'h1, lat);
    check("sub_z",   bus.out_z,   32'h7FFF_FFFF);
    check("sub_ovf", bus.out_ovf, 1);
    check("sub_neg", bus.out_neg, 0);
    consume();
    run_op(C_FUN_SUB, 1'b0, 32'h1, 32'h2, lat);
    check("subu_z",   bus.out_z,   32'hFFFF_FFFF);
    check("subu_ovf", bus.out_ovf, 1);
    consume();
    run_op(C_FUN_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
    check("and_z",   bus.out_z,   32'h00F0_1200);
    check("and_ovf", bus.out_ovf, 0);
    consume();

    op_chk("ltu",  C_FUN_LT,   1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    op_chk("lts",  C_FUN_LT,   1'b1, 32'hFFFF_FFFF, 32'h1,         32'h1,         1);
    op_chk("sra",  C_FUN_SRA,  1'b0, 32'h4,         32'h8000_0000, 32'hF800_0000, 1);
    op_chk("srl",  C_FUN_SRL,  1'b0, 32'h1F,        32'h8000_0000, 32'h1,         1);
    op_chk("sll",  C_FUN_SLL,  1'b0, 32'h24,        32'h1,         32'h10,        1);
    op_chk("or",   C_FUN_OR,   1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1);
    op_chk("xor",  C_FUN_XOR,  1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1);
    op_chk("nor",  C_FUN_NOR,  1'b0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1);
    op_chk("pass", C_FUN_PASS, 1'b0, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 1);
    op_chk("eq",   C_FUN_EQ,   1'b0, 32'h55,        32'h55,        32'h1,         1);
    op_chk("ne",   C_FUN_NE,   1'b0, 32'h55,        32'h55,        32'h0,         1);
    op_chk("lezu", C_FUN_LEZ,  1'b0, 32'h8000_0000, 32'h0,         32'h0,         1);
    op_chk("lezs", C_FUN_LEZ,  1'b1, 32'h8000_0000, 32'h0,         32'h1,         1);
    op_chk("ltzu", C_FUN_LTZ,  1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         1);
    op_chk("gtzs", C_FUN_GTZ,  1'b1, 32'h8000_0000, 32'h0,         32'h0,         1);
    op_chk("gtzu", C_FUN_GTZ,  1'b0, 32'h8000_0000, 32'h0,         32'h1,         1);

    run_op(6'b111000, 1'b1, 32'h1234_5678, 32'h1, lat);
    check("undef_lat",  lat,          1);
    check("undef_z",    bus.out_z,    0);
    check("undef_zero", bus.out_zero, 0);
    check("undef_neg",  bus.out_neg,  0);
    consume();

    run_op(C_FUN_MULT, 1'b1, 32'hFFFF_FFFE, 32'h3, lat);
    check("mul_lat", lat,         33);
    check("mul_z",   bus.out_z,   32'hFFFF_FFFA);
    check("mul_neg", bus.out_neg, 1);
    check("mul_ovf", bus.out_ovf, 0);
    consume();
    op_chk("mul_mfhi", C_FUN_MFHI, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1);
    op_chk("mul_mflo", C_FUN_MFLO, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFA, 1);
    op_chk("mulu",     C_FUN_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    op_chk("mulu_hi",  C_FUN_MFHI, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFE, 1);
    op_chk("mul2",     C_FUN_MULT, 1'b0, 32'h0001_0003, 32'h0000_1000, 32'h1000_3000, 33);
    op_chk("mul2_lo",  C_FUN_MFLO, 1'b0, 32'h0, 32'h0, 32'h1000_3000, 1);
    op_chk("mul2_hi",  C_FUN_MFHI, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1);

`ifdef ALU_DIV_EN
    op_chk("divs",    C_FUN_DIV,  1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
    op_chk("divs_hi", C_FUN_MFHI, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1);
    op_chk("div0",    C_FUN_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 33);
    op_chk("div0_hi", C_FUN_MFHI, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF9, 1);
    run_op(C_FUN_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("divmin_z",   bus.out_z,   32'h8000_0000);
    check("divmin_ovf", bus.out_ovf, 0);
    consume();
    op_chk("divmin_hi", C_FUN_MFHI, 1'b0, 32'h0, 32'h0, 32'h0, 1);
    op_chk("divu",      C_FUN_DIV,  1'b0, 32'd100, 32'd7, 32'd14, 33);
    op_chk("divu_hi",   C_FUN_MFHI, 1'b0, 32'h0, 32'h0, 32'd2, 1);
`else
    run_op(C_FUN_DIV, 1'b1, 32'hFFFF_FFF9, 32'h2, lat);
    check("div_off_lat", lat,         1);
    check("div_off_z",   bus.out_z,   0);
    check("div_off_ovf", bus.out_ovf, 0);
    consume();
    op_chk("div_off_lo", C_FUN_MFLO, 1'b0, 32'h0, 32'h0, 32'h1000_3000, 1);
`endif

    // Abort a MULT 10 cycles in; HI/LO must come back cleared
    op_chk("pre_mul", C_FUN_MULT, 1'b0, 32'h7, 32'h9, 32'd63, 33);
    bus.in_fun   = C_FUN_MULT;
    bus.in_sign  = 1'b0;
    bus.in_a     = 32'h1234_5678;
    bus.in_b     = 32'h9ABC_DEF0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("busy_ready", bus.in_ready, 0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", bus.in_ready,  1);
    check("abort_valid", bus.out_valid, 0);
    op_chk("abort_mflo", C_FUN_MFLO, 1'b0, 32'h0, 32'h0, 32'h0, 1);
    op_chk("abort_mfhi", C_FUN_MFHI, 1'b0, 32'h0, 32'h0, 32'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
